// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator for any progressive display mode. Produces sync,
//   blanking, line/frame strobes and pixel coordinates from a pixel
//   clock-enable running in the Clk domain.
//
//   Optional feature macro: VTG_ODD_FRAME_SKIP_EN
//     When defined, odd frames (field==1) with render_en high drop their
//     last dot: the counters jump from (H_TOTAL-2, V_TOTAL-1) straight to (0,0).
//     When undefined, every frame is H_TOTAL x V_TOTAL dots and render_en is ignored.
//
// Ports
//   Clk         in   system clock, all state changes on rising edge
//   Reset       in   synchronous active-low reset
//   ce          in   pixel enable, one dot per Clk with ce=1
//   render_en   in   qualifies the odd-frame skip
//   hs, vs      out  sync pulses, asserted level HS_POL / VS_POL
//   blank       out  1 = visible pixel
//   sync        out  composite sync, tied 0
//   DrawX/DrawY out  current dot / line
//   vblank      out  1 while DrawY >= V_ACTIVE
//   line_start  out  1 while DrawX == 0
//   frame_start out  1 while DrawX == 0 and DrawY == 0
//   field       out  frame parity, toggles on each frame wrap
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ce,
    input  logic          render_en,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start,
    output logic          field
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SKIP   = CW'(H_TOTAL - 2);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    // Reject degenerate modes and counters too narrow for the raster.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_bad_param
        $error("video_timing_gen: every timing parameter must be >= 1");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_width
        $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] hc, vc, hc_nxt, vc_nxt;
    logic          field_nxt, h_wrap, v_wrap, skip;

`ifdef VTG_ODD_FRAME_SKIP_EN
    assign skip = field && render_en && v_wrap && (hc == H_SKIP);
`else
    logic unused_render_en;
    assign unused_render_en = render_en;
    assign skip = 1'b0;
`endif

    // Next raster position; outputs are decoded from it so they land
    // in the same cycle as the counters they describe.
    always_comb begin
        h_wrap    = (hc == H_LAST);
        v_wrap    = (vc == V_LAST);
        hc_nxt    = hc + ONE;
        vc_nxt    = vc;
        field_nxt = field;
        if (skip) begin
            hc_nxt    = '0;
            vc_nxt    = '0;
            field_nxt = ~field;
        end else if (h_wrap) begin
            hc_nxt = '0;
            if (v_wrap) begin
                vc_nxt    = '0;
                field_nxt = ~field;
            end else begin
                vc_nxt = vc + ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hc          <= '0;
            vc          <= '0;
            field       <= 1'b0;
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            blank       <= 1'b0;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            field       <= field_nxt;
            hs          <= ((hc_nxt >= HS_START) && (hc_nxt < HS_END)) ? HS_ON : ~HS_ON;
            vs          <= ((vc_nxt >= VS_START) && (vc_nxt < VS_END)) ? VS_ON : ~VS_ON;
            blank       <= (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
            vblank      <= (vc_nxt >= V_ACT);
            line_start  <= (hc_nxt == '0);
            frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;
    assign sync  = 1'b0;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    // Three modes share stimulus: 0 = defaults (800x525), 1 = medium (32x19),
    // 2 = small (8x6, HS_POL=1).
    localparam int HA [3] = '{640, 20, 4};
    localparam int HF [3] = '{16, 3, 1};
    localparam int HSW[3] = '{96, 5, 2};
    localparam int HB [3] = '{48, 4, 1};
    localparam int VA [3] = '{480, 12, 3};
    localparam int VF [3] = '{10, 2, 1};
    localparam int VSW[3] = '{2, 3, 1};
    localparam int VB [3] = '{33, 2, 1};
    localparam int HP [3] = '{0, 0, 1};
    localparam int VP [3] = '{0, 1, 0};
`ifdef VTG_ODD_FRAME_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b0, ce = 1'b0, render_en = 1'b0;
    logic [2:0] hs, vs, blank, sync, vblank, line_start, frame_start, field;
    logic [2:0][9:0] dx, dy;

    always #5 Clk = ~Clk;

    video_timing_gen u_def (
        .Clk(Clk), .Reset(Reset), .ce(ce), .render_en(render_en),
        .hs(hs[0]), .vs(vs[0]), .blank(blank[0]), .sync(sync[0]),
        .DrawX(dx[0]), .DrawY(dy[0]), .vblank(vblank[0]),
        .line_start(line_start[0]), .frame_start(frame_start[0]), .field(field[0]));

    video_timing_gen #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                       .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2),
                       .HS_POL(0), .VS_POL(1), .CW(10)) u_med (
        .Clk(Clk), .Reset(Reset), .ce(ce), .render_en(render_en),
        .hs(hs[1]), .vs(vs[1]), .blank(blank[1]), .sync(sync[1]),
        .DrawX(dx[1]), .DrawY(dy[1]), .vblank(vblank[1]),
        .line_start(line_start[1]), .frame_start(frame_start[1]), .field(field[1]));

    video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                       .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                       .HS_POL(1), .VS_POL(0), .CW(10)) u_sml (
        .Clk(Clk), .Reset(Reset), .ce(ce), .render_en(render_en),
        .hs(hs[2]), .vs(vs[2]), .blank(blank[2]), .sync(sync[2]),
        .DrawX(dx[2]), .DrawY(dy[2]), .vblank(vblank[2]),
        .line_start(line_start[2]), .frame_start(frame_start[2]), .field(field[2]));

    // Reference model: position is a dot index within the frame.
    int n[3];
    bit fld[3];
    bit fresh[3] = '{1'b1, 1'b1, 1'b1};
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    function automatic int htot(int k); return HA[k] + HF[k] + HSW[k] + HB[k]; endfunction
    function automatic int vtot(int k); return VA[k] + VF[k] + VSW[k] + VB[k]; endfunction

    function automatic logic [27:0] expv(int k);
        int x, y;
        logic h, v;
        x = n[k] % htot(k);
        y = n[k] / htot(k);
        if (fresh[k])
            return {1'b0, ~HP[k][0], ~VP[k][0], 4'b0000, fld[k], 10'd0, 10'd0};
        h = (x >= HA[k] + HF[k] && x < HA[k] + HF[k] + HSW[k]) ? HP[k][0] : ~HP[k][0];
        v = (y >= VA[k] + VF[k] && y < VA[k] + VF[k] + VSW[k]) ? VP[k][0] : ~VP[k][0];
        return {1'b0, h, v, (x < HA[k] && y < VA[k]), (y >= VA[k]), (x == 0),
                (n[k] == 0), fld[k], x[9:0], y[9:0]};
    endfunction

    function automatic logic [27:0] obsv(int k);
        return {sync[k], hs[k], vs[k], blank[k], vblank[k], line_start[k],
                frame_start[k], field[k], dx[k], dy[k]};
    endfunction

    // Drive one cycle of stimulus and advance the model with what the DUT sampled.
    task automatic step(input bit r, input bit c, input bit e);
        @(negedge Clk);
        Reset = r; ce = c; render_en = e;
        @(posedge Clk);
        for (int k = 0; k < 3; k++) begin
            int ft;
            ft = htot(k) * vtot(k);
            if (!r) begin
                n[k] = 0; fld[k] = 1'b0; fresh[k] = 1'b1;
            end else if (c) begin
                fresh[k] = 1'b0;
                if (n[k] == ft - 1 || (SKIP && fld[k] && e && n[k] == ft - 2)) begin
                    n[k] = 0; fld[k] = ~fld[k];
                end else begin
                    n[k]++;
                end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obsv(k) !== expv(k)) begin
                    n_err++;
                    if (n_err <= 20) $display("FAIL reset inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_free_run();
        int last_rise = -1;
        bit prev_ls = line_start[0];
        for (int i = 0; i < 12000; i++) begin
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obsv(k) !== expv(k)) begin
                    n_err++;
                    if (n_err <= 20) $display("FAIL free_run inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                end
            end
            if (line_start[0] && !prev_ls) begin
                if (last_rise >= 0) begin
                    n_cmp++;
                    if (cyc - last_rise != 800) begin
                        n_err++;
                        $display("FAIL line_period got %0d want 800", cyc - last_rise);
                    end
                end
                last_rise = cyc;
            end
            prev_ls = line_start[0];
        end
    endtask

    task automatic test_sparse_ce();
        int hi_cnt = 0;
        bit seen_rise = 1'b0;
        bit prev_ls = line_start[0];
        for (int i = 0; i < 8000; i++) begin
            step(1'b1, (i % 4 == 3), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obsv(k) !== expv(k)) begin
                    n_err++;
                    if (n_err <= 20) $display("FAIL sparse_ce inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                end
            end
            if (line_start[0]) begin
                if (!prev_ls) seen_rise = 1'b1;
                hi_cnt++;
            end else if (prev_ls && seen_rise) begin
                n_cmp++;
                if (hi_cnt != 4) begin
                    n_err++;
                    $display("FAIL line_start_width got %0d want 4", hi_cnt);
                end
                hi_cnt = 0;
            end else begin
                hi_cnt = 0;
            end
            prev_ls = line_start[0];
        end
    endtask

    task automatic test_random_ce();
        for (int i = 0; i < 20000; i++) begin
            step(1'b1, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obsv(k) !== expv(k)) begin
                    n_err++;
                    if (n_err <= 20) $display("FAIL random_ce inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        for (int rep = 0; rep < 3; rep++) begin
            int len, cnt;
            len = $urandom_range(50, 1500);
            for (int i = 0; i <= len; i++) begin
                // last iteration is the reset cycle
                step((i != len), 1'b1, 1'($urandom_range(0, 1)));
                for (int k = 0; k < 3; k++) begin
                    n_cmp++;
                    if (obsv(k) !== expv(k)) begin
                        n_err++;
                        if (n_err <= 20) $display("FAIL midframe_reset inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                    end
                end
            end
            // After reset, the first frame_start on the medium mode comes a full frame later.
            cnt = 0;
            while (cnt < 700) begin
                step(1'b1, 1'b1, 1'b1);
                cnt++;
                for (int k = 0; k < 3; k++) begin
                    n_cmp++;
                    if (obsv(k) !== expv(k)) begin
                        n_err++;
                        if (n_err <= 20) $display("FAIL post_reset inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                    end
                end
                if (frame_start[1]) break;
            end
            n_cmp++;
            if (cnt != 608) begin
                n_err++;
                $display("FAIL first_frame_after_reset got %0d want 608", cnt);
            end
        end
    endtask

    task automatic test_frame_skip(input bit ren);
        int t_last = -1;
        bit f_last = 1'b0;
        int frames = 0;
        int budget = 0;
        while (frames < 5 && budget < 4000) begin
            step(1'b1, 1'b1, ren);
            budget++;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obsv(k) !== expv(k)) begin
                    n_err++;
                    if (n_err <= 20) $display("FAIL frame_skip inst%0d cyc %0d: got %h want %h", k, cyc, obsv(k), expv(k));
                end
            end
            if (frame_start[1]) begin
                if (t_last >= 0) begin
                    int want;
                    want = (SKIP && ren && f_last) ? 607 : 608;
                    n_cmp++;
                    if (cyc - t_last != want) begin
                        n_err++;
                        $display("FAIL frame_period ren=%0d field=%0d got %0d want %0d", ren, f_last, cyc - t_last, want);
                    end
                end
                t_last = cyc;
                f_last = field[1];
                frames++;
            end
        end
        n_cmp++;
        if (frames < 5) begin
            n_err++;
            $display("FAIL frame_skip_timeout got %0d frames want 5", frames);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sparse_ce();
        test_random_ce();
        test_midframe_reset();
        test_frame_skip(1'b1);
        test_frame_skip(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
